periph_rx_scheduler: RTL
========================

Name: periph_rx_scheduler

Overview:
- Sequential round-robin scheduler that shares the single lycan_to_ftdi FIFO write port between the peripheral RX FIFOs.
- Replaces the stateless grant path that feeds the arbiter mux and the valid mux.
- Adds fair rotation, a per-grant burst limit, urgency pre-emption for almost-full peripherals, and backpressure from the outbound FIFO.
- Outputs a registered grant index for the data mux and one-hot read enables for the peripherals.

Parameters:
- NUM_REQ, 8, number of requesting peripherals. Any value 2..8; need not be a power of 2.
- GRANT_W, 3, width of the grant index. Must be at least $clog2(NUM_REQ).
- MAX_BURST, 16, maximum words read in one grant. Range 1..256.
- BURST_W, 8, width of the burst counter. Must hold MAX_BURST-1.

Ports:
- clk  in  1  FT601-supplied system clock.
- rst_l  in  1  asynchronous active-low reset.
- enable  in  1  scheduler may issue new grants and reads.
- rx_empty  in  NUM_REQ  per-peripheral RX FIFO empty flags (FWFT: data is valid when not empty).
- rx_almost_full  in  NUM_REQ  per-peripheral RX FIFO almost-full flags.
- out_full  in  1  lycan_to_ftdi FIFO full flag.
- grant  out  GRANT_W  registered index of the granted peripheral; drives the data mux select.
- grant_valid  out  1  grant holds a live owner.
- rx_rden  out  NUM_REQ  one-hot read enable; at most one bit high per cycle.
- out_wr  out  1  write enable to lycan_to_ftdi; equals |rx_rden.
- burst_cnt  out  BURST_W  words read in the current grant (debug).

Behaviour:
- Reset (rst_l low, asynchronous): state=IDLE, grant=0, grant_valid=0, rx_rden=0, out_wr=0, burst_cnt=0, rr_ptr=0. Reset takes effect immediately, including mid-burst. No read is issued on the cycle rst_l deasserts.
- States: IDLE, GRANT.
- Request vectors:
  - req = ~rx_empty.
  - urg = req & rx_almost_full.
- Pick function: the first set bit scanning rr_ptr, rr_ptr+1, … with wrap at NUM_REQ-1 to 0. If urg != 0, pick from urg; otherwise pick from req.
- IDLE:
  - If enable and req != 0: register grant=pick, grant_valid=1, burst_cnt=0, go to GRANT.
  - Otherwise stay. Outputs are 0.
  - Latency: request sampled in cycle N gives grant_valid in N+1 and the first rden in N+1.
- GRANT, read rule (combinational from registered state): rx_rden[grant] = enable & ~rx_empty[grant] & ~out_full. All other rx_rden bits are 0.
- GRANT, each read cycle: burst_cnt increments.
- GRANT, exit conditions (evaluated every cycle; the read in the current cycle still completes):
  - a) rx_empty[grant]=1.
  - b) A read occurs with burst_cnt == MAX_BURST-1.
  - c) enable=0.
  - d) Pre-emption: urg has a bit set other than grant while urg[grant]=0.
- GRANT, on exit: rr_ptr = (grant+1) wrapped at NUM_REQ. Go to IDLE, clear grant_valid, keep the grant value.
- Every exit costs at least one dead cycle before the next grant.
- out_full:
  - Stalls reads: no rden, burst_cnt holds, grant held indefinitely.
  - Exit conditions a, c and d still apply.
- Simultaneous events:
  - Empty together with burst limit is a single exit; rr_ptr advances once.
  - A requester that empties in the same cycle it is picked is granted anyway. It exits on the next cycle via rule a with no read.
- MAX_BURST=1: every grant reads exactly one word, giving pure per-word round-robin.
- Fairness: a continuously requesting non-urgent peripheral waits at most (NUM_REQ-1) grants when no urgency is present.
- Invariants:
  - $onehot0(rx_rden).
  - rx_rden != 0 implies grant_valid.
  - out_wr implies ~out_full.

Decomposition:
- lycan_globals package:
  - Reuse num_peripherals for NUM_REQ.
  - Add sched_max_burst (16).
  - Add typedef sched_state_t {SCHED_IDLE, SCHED_GRANT}.
- Sub-module rr_pick: combinational rotate-and-find-first.
  - Inputs: vec [NUM_REQ], ptr [GRANT_W].
  - Outputs: idx [GRANT_W], found.
  - Instantiated twice, once for urg and once for req.

Test Plan:
- Reset, then periph 2 empty=0 with 3 words, all others empty → grant=2 and grant_valid=1 one cycle later; rden[2] high for 3 cycles; IDLE; rr_ptr=3.
- All 8 requesting with deep FIFOs, MAX_BURST=4 → grant order 0,1,2,…,7,0; 4 rdens per grant; one dead cycle between grants; out_wr count=32 per rotation.
- Periph 1 granted mid-burst (2 words read); periph 5 asserts almost_full → periph 1 exits after the current read; next grant=5 despite rr_ptr=2.
- out_full held high 10 cycles during a grant to periph 3 → rx_rden=0, burst_cnt frozen, grant stays 3; resumes on deassert with no lost or duplicated word.
- enable dropped mid-burst → exit next evaluation, grant_valid=0, no further rden until enable=1.
- rst_l asserted mid-burst (grant=6, burst_cnt=3) → all outputs 0 in the same cycle; after release the first grant scans from rr_ptr=0.

Source files
------------

// File: rtl/periph_rx_scheduler_pkg.sv
// Shared constants and FSM state type for the peripheral RX scheduler.
package periph_rx_scheduler_pkg;

  localparam int num_peripherals = 8;
  localparam int sched_max_burst = 16;

  typedef enum logic [0:0] {
    SCHED_IDLE  = 1'b0,
    SCHED_GRANT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/periph_rx_scheduler_rr_pick.sv
// Rotate-and-find-first: returns the first set bit of vec scanning ptr, ptr+1, ...
// with wrap from NUM_REQ-1 back to 0.
module periph_rx_scheduler_rr_pick #(
  parameter int NUM_REQ = 8,
  parameter int GRANT_W = 3
) (
  input  logic [NUM_REQ-1:0] vec,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] idx,
  output logic               found
);

  logic [GRANT_W:0] pos;

  // Scan from the farthest offset down so the nearest hit is written last and wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (GRANT_W + 1)'(i);
      if (pos >= (GRANT_W + 1)'(NUM_REQ)) begin
        pos = pos - (GRANT_W + 1)'(NUM_REQ);
      end
      if (vec[pos[GRANT_W-1:0]]) begin
        idx   = pos[GRANT_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_rx_scheduler.sv
// Round-robin scheduler sharing the lycan_to_ftdi write port between peripheral
// RX FIFOs, with burst limit, almost-full pre-emption and outbound backpressure.
module periph_rx_scheduler
  import periph_rx_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = num_peripherals,
  parameter int GRANT_W   = 3,
  parameter int MAX_BURST = sched_max_burst,
  parameter int BURST_W   = 8
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] rx_empty,
  input  logic [NUM_REQ-1:0] rx_almost_full,
  input  logic               out_full,
  output logic [GRANT_W-1:0] grant,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] rx_rden,
  output logic               out_wr,
  output logic [BURST_W-1:0] burst_cnt
);

  sched_state_t       state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;

  logic [NUM_REQ-1:0] req, urg, grant_oh;
  logic [GRANT_W-1:0] urg_idx, req_idx;
  logic               urg_found, req_found;
  logic               in_grant, g_empty, g_urg, rd_ok, last_word, preempt, exit_grant;

  assign req = ~rx_empty;
  assign urg = req & rx_almost_full;

  periph_rx_scheduler_rr_pick #(.NUM_REQ(NUM_REQ), .GRANT_W(GRANT_W)) u_pick_urg (
    .vec   (urg),
    .ptr   (ptr_q),
    .idx   (urg_idx),
    .found (urg_found)
  );

  periph_rx_scheduler_rr_pick #(.NUM_REQ(NUM_REQ), .GRANT_W(GRANT_W)) u_pick_req (
    .vec   (req),
    .ptr   (ptr_q),
    .idx   (req_idx),
    .found (req_found)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign grant_oh[gi] = (grant_q == GRANT_W'(gi));
    assign rx_rden[gi]  = rd_ok & grant_oh[gi];
  end

  assign in_grant  = (state_q == SCHED_GRANT);
  assign g_empty   = |(rx_empty & grant_oh);
  assign g_urg     = |(urg & grant_oh);
  assign rd_ok     = in_grant & enable & ~g_empty & ~out_full;
  assign last_word = (burst_q == BURST_W'(MAX_BURST - 1));
  // Only pre-empt when the current owner is not itself urgent.
  assign preempt   = (|(urg & ~grant_oh)) & ~g_urg;
  assign exit_grant = g_empty | (rd_ok & last_word) | ~enable | preempt;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if (enable && req_found) begin
          state_d = SCHED_GRANT;
          grant_d = urg_found ? urg_idx : req_idx;
          burst_d = '0;
        end
      end
      SCHED_GRANT: begin
        if (rd_ok) begin
          burst_d = burst_q + BURST_W'(1);
        end
        if (exit_grant) begin
          state_d = SCHED_IDLE;
          ptr_d   = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + GRANT_W'(1);
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= SCHED_IDLE;
      grant_q <= '0;
      burst_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = in_grant;
  assign out_wr      = |rx_rden;
  assign burst_cnt   = burst_q;

endmodule
